// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter_if : request/ack ports and RAM bus of mem_arbiter    |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
interface mem_arbiter_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
);
   logic              p0_req,   p1_req;
   logic              p0_we,    p1_we;
   logic [ADDR_W-1:0] p0_addr,  p1_addr;
   logic [DATA_W-1:0] p0_wdata, p1_wdata;
   logic              p0_ack,   p1_ack;
   logic [DATA_W-1:0] p0_rdata, p1_rdata;
   logic              ram_read, ram_write;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              busy;

   modport slave (
      input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
             p0_wdata, p1_wdata, ram_rdata,
      output p0_ack, p1_ack, p0_rdata, p1_rdata,
             ram_read, ram_write, ram_addr, ram_wdata, busy
   );

   modport master (
      output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
             p0_wdata, p1_wdata, ram_rdata,
      input  p0_ack, p1_ack, p0_rdata, p1_rdata,
             ram_read, ram_write, ram_addr, ram_wdata, busy
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arbiter : two-port arbiter/sequencer for the 512x32 RAM      |
// | Option macro: ROUND_ROBIN_EN (alternate grants on ties)          |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module mem_arbiter #(
   parameter int ADDR_W      = 9,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 1
) (
   input  wire logic     clock,
   input  wire logic     clear,
   mem_arbiter_if.slave  bus
);
   localparam logic [3:0] c_CNT_LOAD = 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic              r_grant;
   logic              r_we;
   logic              r_ram_read;
   logic              r_ram_write;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [DATA_W-1:0] r_ram_wdata;
   logic              r_p0_ack;
   logic              r_p1_ack;
   logic [DATA_W-1:0] r_p0_rdata;
   logic [DATA_W-1:0] r_p1_rdata;
   logic              r_busy;
`ifdef ROUND_ROBIN_EN
   logic              r_last_grant;
`endif

   logic              w_any;
   logic              w_pick;
   logic              w_we;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;

   assign w_any = bus.p0_req | bus.p1_req;

   always_comb begin
      w_pick = 1'b0;
      if (bus.p1_req && !bus.p0_req)
         w_pick = 1'b1;
`ifdef ROUND_ROBIN_EN
      else if (bus.p0_req && bus.p1_req)
         w_pick = ~r_last_grant;
`endif
   end

   assign w_we    = w_pick ? bus.p1_we    : bus.p0_we;
   assign w_addr  = w_pick ? bus.p1_addr  : bus.p0_addr;
   assign w_wdata = w_pick ? bus.p1_wdata : bus.p0_wdata;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_grant     <= 1'b0;
         r_we        <= 1'b0;
         r_ram_read  <= 1'b0;
         r_ram_write <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_p0_ack    <= 1'b0;
         r_p1_ack    <= 1'b0;
         r_p0_rdata  <= '0;
         r_p1_rdata  <= '0;
         r_busy      <= 1'b0;
`ifdef ROUND_ROBIN_EN
         r_last_grant <= 1'b1;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state     <= S_ACCESS;
                  r_grant     <= w_pick;
                  r_cnt       <= c_CNT_LOAD;
                  r_we        <= w_we;
                  r_ram_addr  <= w_addr;
                  r_ram_wdata <= w_wdata;
                  r_ram_read  <= ~w_we;
                  r_ram_write <= w_we;
                  r_busy      <= 1'b1;
`ifdef ROUND_ROBIN_EN
                  r_last_grant <= w_pick;
`endif
               end
            end
            S_ACCESS: begin
               if (r_cnt == 4'd0) begin
                  r_state     <= S_DONE;
                  r_ram_read  <= 1'b0;
                  r_ram_write <= 1'b0;
                  if (r_grant) r_p1_ack <= 1'b1;
                  else         r_p0_ack <= 1'b1;
                  // Capture on the last strobe edge, while ram_read is still high
                  if (!r_we) begin
                     if (r_grant) r_p1_rdata <= bus.ram_rdata;
                     else         r_p0_rdata <= bus.ram_rdata;
                  end
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_DONE: begin
               r_state  <= S_IDLE;
               r_p0_ack <= 1'b0;
               r_p1_ack <= 1'b0;
               r_busy   <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.ram_read  = r_ram_read;
   assign bus.ram_write = r_ram_write;
   assign bus.ram_addr  = r_ram_addr;
   assign bus.ram_wdata = r_ram_wdata;
   assign bus.p0_ack    = r_p0_ack;
   assign bus.p1_ack    = r_p1_ack;
   assign bus.p0_rdata  = r_p0_rdata;
   assign bus.p1_rdata  = r_p1_rdata;
   assign bus.busy      = r_busy;
endmodule
`default_nettype wire
